// File: rtl/result_credit_fifo_pkg.sv
// Shared convolution-engine constants and the up/down counter helper used by
// the result credit FIFO.
package result_credit_fifo_pkg;

   localparam int CeDataWidth = 32;
   localparam int MacLatency  = 7;

   typedef enum logic [1:0] {
      CRED_HOLD = 2'd0,
      CRED_INC  = 2'd1,
      CRED_DEC  = 2'd2
   } cred_op_e;

   // A simultaneous increment and decrement cancels out.
   function automatic cred_op_e cred_op(input logic inc, input logic dec);
      cred_op_e op;
      case ({inc, dec})
         2'b10:   op = CRED_INC;
         2'b01:   op = CRED_DEC;
         default: op = CRED_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/result_credit_fifo_result_ram.sv
// Result storage: one write port, one asynchronous read port, wrapping pointers.
// Storage is intentionally left unreset; only the pointers clear.
module result_ram #(
   parameter int DataWidth = 32,
   parameter int Depth     = 8
) (
   input  logic                 clk,
   input  logic                 aclr_n,
   input  logic                 wr_en,
   input  logic [DataWidth-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DataWidth-1:0] rd_data
);

   localparam int AddrW = $clog2(Depth);

   logic [DataWidth-1:0] mem_r [Depth];
   logic [AddrW-1:0]     wr_ptr_r;
   logic [AddrW-1:0]     rd_ptr_r;

   // Pointers wrap naturally because Depth is a power of two.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr_r <= {AddrW{1'b0}};
         rd_ptr_r <= {AddrW{1'b0}};
      end else begin
         if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + AddrW'(1);
         end
         if (rd_en) begin
            rd_ptr_r <= rd_ptr_r + AddrW'(1);
         end
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/result_credit_fifo.sv
// Credit-gated result buffer behind the multiply-add pipeline: issue is only
// allowed while every outstanding operation is guaranteed a buffer slot.
module result_credit_fifo
   import result_credit_fifo_pkg::*;
#(
   parameter int DataWidth = CeDataWidth,
   parameter int Depth     = 8
) (
   input  logic                         clk,
   input  logic                         aclr_n,
   output logic                         issue_ready,
   input  logic                         issue_valid,
   input  logic                         res_valid,
   input  logic [DataWidth-1:0]         res_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DataWidth-1:0]         out_data,
   output logic [$clog2(Depth+1)-1:0]   in_flight,
   output logic [$clog2(Depth+1)-1:0]   count,
   output logic                         err
);

   localparam int CntW = $clog2(Depth + 1);
   localparam logic [CntW:0]   DepthExt = (CntW + 1)'(Depth);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
   localparam logic [CntW-1:0] ZeroCnt  = {CntW{1'b0}};
   localparam logic [CntW-1:0] OneCnt   = CntW'(1);

   logic [CntW-1:0] in_flight_r;
   logic [CntW-1:0] count_r;
   logic            err_r;

   logic [CntW:0]   used_s;
   logic            issue_ready_s;
   logic            out_valid_s;
   logic            issue_fire_s;
   logic            bad_issue_s;
   logic            orphan_s;
   logic            ret_s;
   logic            push_s;
   logic            pop_s;
   cred_op_e        if_op_s;
   cred_op_e        cnt_op_s;

   // Credit check and event decode; an orphan result never returns a credit.
   always_comb begin
      used_s        = {1'b0, count_r} + {1'b0, in_flight_r};
      issue_ready_s = (used_s < DepthExt);
      out_valid_s   = (count_r != ZeroCnt);
      issue_fire_s  = issue_valid & issue_ready_s;
      bad_issue_s   = issue_valid & ~issue_ready_s;
      orphan_s      = res_valid & (in_flight_r == ZeroCnt);
      ret_s         = res_valid & ~orphan_s;
      push_s        = res_valid & (count_r != DepthCnt);
      pop_s         = out_valid_s & out_ready;
      if_op_s       = cred_op(issue_fire_s, ret_s);
      cnt_op_s      = cred_op(push_s, pop_s);
   end

   // Credit, occupancy and sticky error state.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         in_flight_r <= ZeroCnt;
         count_r     <= ZeroCnt;
         err_r       <= 1'b0;
      end else begin
         case (if_op_s)
            CRED_INC: in_flight_r <= in_flight_r + OneCnt;
            CRED_DEC: in_flight_r <= in_flight_r - OneCnt;
            default:  in_flight_r <= in_flight_r;
         endcase
         case (cnt_op_s)
            CRED_INC: count_r <= count_r + OneCnt;
            CRED_DEC: count_r <= count_r - OneCnt;
            default:  count_r <= count_r;
         endcase
         if (bad_issue_s || orphan_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   result_ram #(
      .DataWidth (DataWidth),
      .Depth     (Depth)
   ) u_ram (
      .clk     (clk),
      .aclr_n  (aclr_n),
      .wr_en   (push_s),
      .wr_data (res_data),
      .rd_en   (pop_s),
      .rd_data (out_data)
   );

   assign issue_ready = issue_ready_s;
   assign out_valid   = out_valid_s;
   assign in_flight   = in_flight_r;
   assign count       = count_r;
   assign err         = err_r;

endmodule

// File: tb/tb_result_credit_fifo.sv
// Directed table-driven bench for result_credit_fifo (DataWidth 32, Depth 8),
// with hand-written sequences for wrap, protocol errors and async reset.
module tb_result_credit_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          aclr_n;
   logic          issue_ready;
   logic          issue_valid;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [3:0]    in_flight;
   logic [3:0]    count;
   logic          err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        iv;
      logic        rv;
      logic [31:0] rd;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      int          e_if;
      int          e_cnt;
      logic        e_err;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] q[$];
   int          tif;
   logic        rdy, miv, mrv, mor;

   result_credit_fifo #(.DataWidth(DW), .Depth(DEPTH)) dut (
      .clk         (clk),
      .aclr_n      (aclr_n),
      .issue_ready (issue_ready),
      .issue_valid (issue_valid),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .in_flight   (in_flight),
      .count       (count),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic ir, input logic ov,
                              input logic [31:0] od, input int fi, input int cn,
                              input logic er);
      chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(ir));
      chk({tag, ".out_valid"},   32'(out_valid),   32'(ov));
      chk({tag, ".in_flight"},   32'(in_flight),   32'(fi));
      chk({tag, ".count"},       32'(count),       32'(cn));
      chk({tag, ".err"},         32'(err),         32'(er));
      if (ov) chk({tag, ".out_data"}, out_data, od);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0;
      res_valid   = 1'b0;
      res_data    = 32'h0;
      out_ready   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      aclr_n = 1'b0;
      step();
      aclr_n = 1'b1;
   endtask

   task automatic add(input logic iv, input logic rv, input logic [31:0] rd, input logic ordy,
                      input logic ir, input logic ov, input logic [31:0] od,
                      input int fi, input int cn, input logic er);
      vec_t v;
      v = '{iv, rv, rd, ordy, ir, ov, od, fi, cn, er};
      vecs.push_back(v);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $fatal(1);
   end

   initial begin
      // Fill: 8 issues, wait, 8 results, drain
      for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 32'h0, 1'b0, (k < 7), 1'b0, 32'h0, k + 1, 0, 1'b0);
      for (int k = 0; k < 6; k++) add(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 8, 0, 1'b0);
      for (int k = 0; k < 8; k++) add(1'b0, 1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0, 1'b1, 32'hA0, 7 - k, k + 1, 1'b0);
      for (int k = 0; k < 8; k++) add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, (k < 7), 32'hA0 + 32'(k + 1), 0, 7 - k, 1'b0);
      // In-order presentation, one cycle after each result strobe
      for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, k + 1, 0, 1'b0);
      add(1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 2, 1, 1'b0);
      add(1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 1, 1, 1'b0);
      add(1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 0, 1, 1'b0);
      add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  0, 0, 1'b0);
      // Reach count 3, then a simultaneous push and pop
      for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, k + 1, 0, 1'b0);
      for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 32'hC0 + 32'(k), 1'b0, 1'b1, 1'b1, 32'hC0, 3 - k, k + 1, 1'b0);
      add(1'b0, 1'b1, 32'hC3, 1'b1, 1'b1, 1'b1, 32'hC1, 0, 3, 1'b0);

      aclr_n = 1'b1;
      idle_inputs();
      do_reset();
      check_state("reset", 1'b1, 1'b0, 32'h0, 0, 0, 1'b0);
      step();
      step();
      check_state("idle", 1'b1, 1'b0, 32'h0, 0, 0, 1'b0);

      foreach (vecs[i]) begin
         issue_valid = vecs[i].iv;
         res_valid   = vecs[i].rv;
         res_data    = vecs[i].rd;
         out_ready   = vecs[i].ordy;
         step();
         check_state($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od,
                     vecs[i].e_if, vecs[i].e_cnt, vecs[i].e_err);
      end

      // Mixed traffic from count 3 across pointer wrap, then drain
      q = {32'hC1, 32'hC2, 32'hC3};
      tif = 0;
      for (int i = 0; i < 32; i++) begin
         rdy = ((q.size() + tif) < DEPTH);
         if (i < 20) begin
            miv = rdy && ((i % 3) != 2);
            mrv = (tif > 0) && ((i % 2) == 0);
            mor = ((i % 4) != 3);
         end else begin
            miv = 1'b0;
            mrv = (tif > 0);
            mor = 1'b1;
         end
         issue_valid = miv;
         res_valid   = mrv;
         res_data    = 32'hD0 + 32'(i);
         out_ready   = mor;
         if (mor && (q.size() != 0)) void'(q.pop_front());
         if (mrv) q.push_back(32'hD0 + 32'(i));
         tif = tif + (miv ? 1 : 0) - (mrv ? 1 : 0);
         step();
         check_state($sformatf("mix%0d", i), ((q.size() + tif) < DEPTH), (q.size() != 0),
                     (q.size() != 0) ? q[0] : 32'h0, tif, q.size(), 1'b0);
      end
      idle_inputs();

      // Issue while not ready is ignored and flags err
      do_reset();
      issue_valid = 1'b1;
      for (int k = 0; k < 8; k++) step();
      check_state("full_issue", 1'b0, 1'b0, 32'h0, 8, 0, 1'b0);
      step();
      check_state("bad_issue", 1'b0, 1'b0, 32'h0, 8, 0, 1'b1);
      issue_valid = 1'b0;
      step();
      check_state("bad_issue_sticky", 1'b0, 1'b0, 32'h0, 8, 0, 1'b1);

      // Orphan result still stored, err sticky
      do_reset();
      check_state("reset2", 1'b1, 1'b0, 32'h0, 0, 0, 1'b0);
      res_valid = 1'b1;
      res_data  = 32'h5A;
      step();
      res_valid = 1'b0;
      check_state("orphan", 1'b1, 1'b1, 32'h5A, 0, 1, 1'b1);
      for (int k = 0; k < 3; k++) step();
      check_state("orphan_sticky", 1'b1, 1'b1, 32'h5A, 0, 1, 1'b1);

      // Async reset mid-operation clears before the next edge
      do_reset();
      issue_valid = 1'b1;
      for (int k = 0; k < 8; k++) step();
      issue_valid = 1'b0;
      res_valid   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         res_data = 32'hE0 + 32'(k);
         step();
      end
      res_valid = 1'b0;
      check_state("pre_clr", 1'b0, 1'b1, 32'hE0, 3, 5, 1'b0);
      #2;
      aclr_n = 1'b0;
      #1;
      check_state("async_clr", 1'b1, 1'b0, 32'h0, 0, 0, 1'b0);
      step();
      check_state("clr_held", 1'b1, 1'b0, 32'h0, 0, 0, 1'b0);
      aclr_n    = 1'b1;
      res_valid = 1'b1;
      res_data  = 32'h77;
      step();
      res_valid = 1'b0;
      check_state("late_result", 1'b1, 1'b1, 32'h77, 0, 1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_credit_fifo.md
RESULT_CREDIT_FIFO -- requirements
Module: result_credit_fifo

Interface
REQ-001 Parameter DataWidth, default 32, width of one multiply-add result.
REQ-002 Parameter Depth, default 8, result buffer entries; power of two, at least 2.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port aclr_n  input  1  asynchronous, active-low reset.
REQ-005 Port issue_ready  output  1  upstream may launch one operation into the multiply-add pipeline this cycle.
REQ-006 Port issue_valid  input  1  upstream launches one operation this cycle.
REQ-007 Port res_valid  input  1  pipeline result strobe, taken from the valid shift pipeline output.
REQ-008 Port res_data  input  DataWidth  pipeline result, qualified by res_valid.
REQ-009 Port out_valid  output  1  buffer holds at least one result.
REQ-010 Port out_ready  input  1  downstream accepts the head result.
REQ-011 Port out_data  output  DataWidth  head result, valid while out_valid is high.
REQ-012 Port in_flight  output  clog2(Depth+1)  operations issued but not yet returned.
REQ-013 Port count  output  clog2(Depth+1)  results stored.
REQ-014 Port err  output  1  sticky protocol-error flag.

Function
REQ-015 The block SHALL guarantee no result loss: count + in_flight never exceeds Depth.
REQ-016 The block SHALL drive issue_ready = 1 when count + in_flight < Depth (combinational), else 0.
REQ-017 An issue event (issue_valid && issue_ready) SHALL increment in_flight next cycle.
REQ-018 A res_valid pulse SHALL write res_data at the write pointer and decrement in_flight.
REQ-019 Simultaneous issue and res_valid in one cycle SHALL leave in_flight unchanged.
REQ-020 The block SHALL drive out_valid = (count != 0) and out_data = entry at the read pointer; no fall-through, so a result written in cycle N is visible at cycle N+1.
REQ-021 A pop (out_valid && out_ready) SHALL advance the read pointer and decrement count.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 Read and write pointers SHALL be clog2(Depth) bits and wrap from Depth-1 to 0.
REQ-024 out_ready with out_valid low SHALL have no effect.
REQ-025 issue_valid with issue_ready low SHALL be ignored (no in_flight change) and SHALL set err.
REQ-026 res_valid with in_flight = 0 SHALL set err; the result is still written if count < Depth, otherwise it is dropped.
REQ-027 err, once set, SHALL remain high until reset.

Reset
REQ-028 While aclr_n is low, the block SHALL asynchronously clear in_flight, count, both pointers and err.
REQ-029 During and after reset, out_valid SHALL be 0 and issue_ready SHALL be 1.
REQ-030 Buffer storage SHALL not be reset; out_data is don't-care while out_valid is 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered and in-flight accounting; results arriving afterwards set err per REQ-026.

Structure
REQ-032 DataWidth and the multiply-add latency constant (7) SHALL live in the shared convolution-engine package.
REQ-033 The storage array plus pointers SHALL form one sub-module, result_ram, with one write port and one asynchronous read port.
REQ-034 Credit and occupancy counters SHALL reside in the top module.

Verification
REQ-035 Reset then idle -> issue_ready = 1, out_valid = 0, count = 0, in_flight = 0, err = 0.
REQ-036 Issue 8 operations back-to-back with Depth 8 and out_ready = 0 -> issue_ready falls after the 8th; in_flight = 8; results returning 7 cycles later fill count to 8 with issue_ready still 0.
REQ-037 Return results 0x11, 0x22, 0x33 with out_ready = 1 -> out_data presents 0x11, 0x22, 0x33 in order, each one cycle after its res_valid.
REQ-038 count = 3 plus one push and one pop in the same cycle -> count stays 3; order is preserved across pointer wrap after 20 mixed operations.
REQ-039 Drive issue_valid while issue_ready = 0, and res_valid while in_flight = 0 -> err rises and stays high; in_flight is unchanged by the ignored issue.
REQ-040 Assert aclr_n low with count = 5 and in_flight = 3 -> all counters read 0 immediately, before the next clock edge; issue_ready = 1.
